instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `rst`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `reqValid`, input, 1 bit: request present.
REQ-005 Port `reqReady`, output, 1 bit: the block can accept a request.
REQ-006 Port `kind`, input, 3 bits: instruction class. 0=R (0110011), 1=I (0010011), 2=S (0100011), 3=B (1100011), 4=LUI (0110111), 5=JAL (1101111), 6=LW (0000011), 7=JALR (1100111).
REQ-007 Ports `rd`, `rs1`, `rs2`, inputs, 5 bits each: register indices.
REQ-008 Port `func3`, input, 3 bits: operation select.
REQ-009 Port `f7b5`, input, 1 bit: instruction bit 30 (sub/sra/srai).
REQ-010 Port `imm`, input, 32 bits: signed immediate, byte offset for B/J.
REQ-011 Port `instrValid`, output, 1 bit: encoded word available.
REQ-012 Port `instrReady`, input, 1 bit: consumer accepts the word.
REQ-013 Port `instr`, output, 32 bits: encoded instruction.
REQ-014 Port `instrErr`, output, 1 bit: the word at the head came from an illegal request.
REQ-015 Port `encCount`, output, 16 bits: number of accepted requests.

Function
REQ-016 A push SHALL occur on a rising edge with reqValid && reqReady; a pop SHALL occur on a rising edge with instrValid && instrReady.
REQ-017 A 2-entry FIFO SHALL hold {instr, instrErr} entries, with reqReady = (count < 2) and instrValid = (count != 0).
REQ-018 reqReady SHALL depend only on the registered count, with no combinational path from instrReady.
REQ-019 Latency: a word pushed at edge N SHALL be visible on instr at N+1 if the FIFO was empty.
REQ-020 Simultaneous push and pop at count 1 SHALL leave count at 1, with the new word at the head after the edge.
REQ-021 Ordering SHALL be strictly FIFO.
REQ-022 When count == 0, instr SHALL be 0 and instrErr SHALL be 0.
REQ-023 R encoding SHALL be {0,f7b5,00000, rs2, rs1, func3, rd, op}.
REQ-024 I encoding SHALL be {imm[11:0], rs1, func3, rd, op}; for func3 001 or 101, bits[31:25] SHALL be {0,f7b5,00000}.
REQ-025 LW SHALL use the I layout with func3 forced to 010.
REQ-026 JALR SHALL use the I layout with func3 forced to 000.
REQ-027 S encoding SHALL be {imm[11:5], rs2, rs1, 010, imm[4:0], op}, with func3 forced.
REQ-028 B encoding SHALL be {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op}.
REQ-029 LUI encoding SHALL be {imm[31:12], rd, op}.
REQ-030 JAL encoding SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-031 An error SHALL be flagged for any of the following:
- B with func3 not in {000, 001};
- B or JAL with imm[0] == 1;
- I/S/LW/JALR with imm[31:11] not all-equal;
- B with imm[31:12] not all-equal;
- JAL with imm[31:20] not all-equal.
REQ-032 An errored request SHALL still be accepted and pushed with the truncated encoding and instrErr = 1.
REQ-033 Fields not used by a class (e.g. rs2 for I, rd for S/B) SHALL be ignored.
REQ-034 encCount SHALL increment on every push, including errored ones, and wrap from 0xFFFF to 0x0000.

Reset
REQ-035 Reset assertion SHALL immediately and asynchronously set count = 0, encCount = 0, instrValid = 0, instr = 0 and instrErr = 0, and set reqReady to 1.
REQ-036 FIFO entries SHALL be discarded on reset, including mid-transfer.
REQ-037 The first push SHALL be accepted on the first rising edge after reset deassertion.

Verification
REQ-038 Basic encodings, each pushed with instrReady = 1, SHALL produce the following one cycle later with instrErr = 0:
- R add x3,x1,x2 (kind=0, func3=0, f7b5=0) -> 0x002081B3;
- the same with f7b5=1 -> 0x402081B3.
REQ-039 LW x5,8(x2) (kind=6, rd=5, rs1=2, imm=8, func3=000 supplied) -> 0x00812283, with func3 forced to 010.
REQ-040 BEQ x1,x2,+8 (kind=3, func3=000, imm=8) -> 0x00208463; JAL x1,+16 (kind=5, imm=16) -> 0x010000EF; LUI x5,0x12345 (imm=0x12345000) -> 0x123452B7.
REQ-041 Backpressure: with instrReady = 0 and three back-to-back requests, the bench SHALL observe:
- reqReady falls after the 2nd push and the 3rd request stalls;
- raising instrReady drains the words in order;
- the 3rd request is accepted on the edge after the first pop;
- encCount = 3 at the end.
REQ-042 Errors: B with func3=100 -> instrErr=1; JAL with imm=3 -> instrErr=1; I with imm=0x800 -> instrErr=1; encCount still increments in each case.
REQ-043 Reset and wrap: assert rst with 2 words queued -> instrValid=0, reqReady=1, encCount=0 immediately; separately, preload 0xFFFF pushes -> the next push gives encCount=0x0000.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Illegal requests are still encoded (truncated) and tagged with instrErr.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic        instrErr,
  output logic [15:0] encCount
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [31:0] word;
  logic        err;
  logic        ok11, ok12, ok20;

  // Sign-extension checks: upper bits must all be copies of the sign.
  assign ok11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign ok12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign ok20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word = '0;
    err  = 1'b0;
    unique case (kind)
      3'd0: word = {1'b0, f7b5, 5'b0, rs2, rs1, func3, rd, OP_R};
      3'd1: begin
        word = {imm[11:0], rs1, func3, rd, OP_I};
        if (func3 == 3'b001 || func3 == 3'b101)
          word[31:25] = {1'b0, f7b5, 5'b0};
        err = ~ok11;
      end
      3'd2: begin
        word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_S};
        err = ~ok11;
      end
      3'd3: begin
        word = {imm[12], imm[10:5], rs2, rs1, func3,
                imm[4:1], imm[11], OP_B};
        err = (func3[2:1] != 2'b00) | imm[0] | ~ok12;
      end
      3'd4: word = {imm[31:12], rd, OP_LUI};
      3'd5: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        err = imm[0] | ~ok20;
      end
      3'd6: begin
        word = {imm[11:0], rs1, 3'b010, rd, OP_LW};
        err = ~ok11;
      end
      3'd7: begin
        word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        err = ~ok11;
      end
      default: word = '0;
    endcase
  end

  logic [32:0] mem0, mem1;
  logic [1:0]  cnt;
  logic        rdp, wrp;
  logic        push, pop;
  logic [32:0] head;

  assign reqReady   = ~cnt[1];
  assign instrValid = (cnt != 2'd0);
  assign push       = reqValid & reqReady;
  assign pop        = instrValid & instrReady;
  assign head       = rdp ? mem1 : mem0;
  assign instr      = instrValid ? head[31:0] : 32'h0;
  assign instrErr   = instrValid ? head[32] : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0     <= '0;
      mem1     <= '0;
      cnt      <= 2'd0;
      rdp      <= 1'b0;
      wrp      <= 1'b0;
      encCount <= 16'h0;
    end else begin
      if (push) begin
        if (wrp) mem1 <= {err, word};
        else     mem0 <= {err, word};
        wrp      <= ~wrp;
        encCount <= encCount + 16'd1;
      end
      if (pop) rdp <= ~rdp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
